// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational logical unit among NUM_REQ requesters.
// Optional error flag for non-logical opcodes is enabled with `define LU_ARB_ERR_EN.
module logic_unit_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned WORD_SIZE   = 19,
   parameter int unsigned OPCODE_SIZE = 5,
   parameter logic [OPCODE_SIZE-1:0] OP_AND = OPCODE_SIZE'(1),
   parameter logic [OPCODE_SIZE-1:0] OP_OR  = OPCODE_SIZE'(2),
   parameter logic [OPCODE_SIZE-1:0] OP_XOR = OPCODE_SIZE'(3),
   parameter logic [OPCODE_SIZE-1:0] OP_NOT = OPCODE_SIZE'(4)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*OPCODE_SIZE-1:0] req_opcode,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   req_operand_1,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   req_operand_2,
   output logic [OPCODE_SIZE-1:0]         lu_opcode,
   output logic [WORD_SIZE-1:0]           lu_operand_1,
   output logic [WORD_SIZE-1:0]           lu_operand_2,
   input  logic [WORD_SIZE-1:0]           lu_out,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
   output logic [WORD_SIZE-1:0]           rsp_data,
   output logic                           busy
`ifdef LU_ARB_ERR_EN
   ,
   output logic                           rsp_err
`endif
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e                   state_q, state_d;
   logic [IdW-1:0]           last_grant_q;
   logic [IdW-1:0]           grant_idx;
   logic                     grant_found;
   logic                     do_grant;
   logic [OPCODE_SIZE-1:0]   lu_opcode_q;
   logic [WORD_SIZE-1:0]     lu_operand_1_q, lu_operand_2_q;
   logic                     rsp_valid_q;
   logic [IdW-1:0]           rsp_id_q;
   logic [WORD_SIZE-1:0]     rsp_data_q;

   // Search upward from last_grant+1, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         idx = (int'(last_grant_q) + k) % int'(NUM_REQ);
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = IdW'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      do_grant = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_found) begin
               do_grant = 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: state_d = StResp;
         StResp: begin
            if (rsp_ready) begin
               if (grant_found) begin
                  do_grant = 1'b1;
                  state_d  = StIssue;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      req_ready = '0;
      if (do_grant) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         last_grant_q   <= IdW'(NUM_REQ - 1);
         lu_opcode_q    <= '0;
         lu_operand_1_q <= '0;
         lu_operand_2_q <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_data_q     <= '0;
      end else begin
         state_q <= state_d;
         if (do_grant) begin
            lu_opcode_q    <= req_opcode[int'(grant_idx)*OPCODE_SIZE +: OPCODE_SIZE];
            lu_operand_1_q <= req_operand_1[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
            lu_operand_2_q <= req_operand_2[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
            rsp_id_q       <= grant_idx;
            last_grant_q   <= grant_idx;
         end
         if (state_q == StIssue) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= lu_out;
         end else if (state_q == StResp && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

`ifdef LU_ARB_ERR_EN
   logic rsp_err_q;
   logic illegal_op;

   assign illegal_op = !(lu_opcode_q inside {OP_AND, OP_OR, OP_XOR, OP_NOT});

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_err_q <= 1'b0;
      end else if (state_q == StIssue) begin
         rsp_err_q <= illegal_op;
      end else if (state_q == StResp && rsp_ready) begin
         rsp_err_q <= 1'b0;
      end
   end

   assign rsp_err = rsp_err_q;
`endif

   assign lu_opcode    = lu_opcode_q;
   assign lu_operand_1 = lu_operand_1_q;
   assign lu_operand_2 = lu_operand_2_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_data     = rsp_data_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_logic_unit_arbiter;

   localparam int NR = 4;
   localparam int WS = 19;
   localparam int OS = 5;
   localparam logic [OS-1:0] OP_AND = 5'd1;
   localparam logic [OS-1:0] OP_OR  = 5'd2;
   localparam logic [OS-1:0] OP_XOR = 5'd3;
   localparam logic [OS-1:0] OP_NOT = 5'd4;

   logic               clk = 1'b0;
   logic               rst;
   logic [NR-1:0]      req_valid;
   logic [NR-1:0]      req_ready;
   logic [NR*OS-1:0]   req_opcode;
   logic [NR*WS-1:0]   req_operand_1, req_operand_2;
   logic [OS-1:0]      lu_opcode;
   logic [WS-1:0]      lu_operand_1, lu_operand_2, lu_out;
   logic               rsp_valid, rsp_ready;
   logic [1:0]         rsp_id;
   logic [WS-1:0]      rsp_data;
   logic               busy;
`ifdef LU_ARB_ERR_EN
   logic               rsp_err;
`endif

   typedef struct packed {
      logic [1:0]    id;
      logic [WS-1:0] data;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   hs_count = 0;

   always #5 clk = ~clk;

   logic_unit_arbiter #(
      .NUM_REQ(NR), .WORD_SIZE(WS), .OPCODE_SIZE(OS),
      .OP_AND(OP_AND), .OP_OR(OP_OR), .OP_XOR(OP_XOR), .OP_NOT(OP_NOT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_operand_1(req_operand_1), .req_operand_2(req_operand_2),
      .lu_opcode(lu_opcode), .lu_operand_1(lu_operand_1), .lu_operand_2(lu_operand_2),
      .lu_out(lu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy)
`ifdef LU_ARB_ERR_EN
      , .rsp_err(rsp_err)
`endif
   );

   // Reference logical unit
   always_comb begin
      lu_out = '0;
      case (lu_opcode)
         OP_AND:  lu_out = lu_operand_1 & lu_operand_2;
         OP_OR:   lu_out = lu_operand_1 | lu_operand_2;
         OP_XOR:  lu_out = lu_operand_1 ^ lu_operand_2;
         OP_NOT:  lu_out = ~lu_operand_1;
         default: lu_out = '0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic set_req(input int i, input logic [OS-1:0] op, input logic [WS-1:0] a,
                          input logic [WS-1:0] b);
      req_opcode[i*OS +: OS]    = op;
      req_operand_1[i*WS +: WS] = a;
      req_operand_2[i*WS +: WS] = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && rsp_valid && rsp_ready) begin
         hs_count++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got id=%0d data=0x%0h expected none", rsp_id, rsp_data);
         end else begin
            e = sb.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
`ifdef LU_ARB_ERR_EN
            check("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_opcode = '0;
      req_operand_1 = '0;
      req_operand_2 = '0;

      // Reset state
      step(); step();
      rst = 1'b0;
      step();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_lu_opcode", 32'(lu_opcode), 32'h0);
      check("rst_lu_op1", 32'(lu_operand_1), 32'h0);
      check("rst_lu_op2", 32'(lu_operand_2), 32'h0);

      // Single AND from requester 2
      step();
      rsp_ready = 1'b1;
      set_req(2, OP_AND, 19'h7FFFF, 19'h0F0F0);
      req_valid = 4'b0100;
      @(negedge clk);
      check("and_req_ready", 32'(req_ready), 32'h4);
      sb.push_back('{id: 2'd2, data: 19'h0F0F0, err: 1'b0});
      step();
      req_valid = '0;
      @(negedge clk);
      check("and_lu_op1", 32'(lu_operand_1), 32'h7FFFF);
      check("and_busy", 32'(busy), 32'h1);
      check("and_valid_t1", 32'(rsp_valid), 32'h0);
      step();
      @(negedge clk);
      check("and_valid_t2", 32'(rsp_valid), 32'h1);
      step();
      step();

      // Round-robin after fresh reset
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, OP_XOR, 19'(i), 19'h40000);
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         check("rr_grant", 32'(req_ready), 32'(1 << (g % NR)));
         sb.push_back('{id: 2'(g % NR), data: 19'h40000 | 19'(g % NR), err: 1'b0});
         step();
         if (g == 4) req_valid = '0;
         @(negedge clk);
         check("rr_issue_ready", 32'(req_ready), 32'h0);
         step();
      end
      step();

      // Backpressure: NOT from requester 1, requester 3 waiting
      rsp_ready = 1'b0;
      set_req(1, OP_NOT, 19'h00000, 19'h00000);
      req_valid = 4'b0010;
      @(negedge clk);
      check("bp_grant", 32'(req_ready), 32'h2);
      sb.push_back('{id: 2'd1, data: 19'h7FFFF, err: 1'b0});
      step();
      set_req(3, OP_OR, 19'h12345, 19'h00F00);
      req_valid = 4'b1000;
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'h1);
         check("bp_data", 32'(rsp_data), 32'h7FFFF);
         check("bp_id", 32'(rsp_id), 32'h1);
         check("bp_req_ready", 32'(req_ready), 32'h0);
         step();
      end
      hs0 = hs_count;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_next_grant", 32'(req_ready), 32'h8);
      sb.push_back('{id: 2'd3, data: 19'h12F45, err: 1'b0});
      step();
      req_valid = '0;
      @(negedge clk);
      check("bp_one_hs", 32'(hs_count - hs0), 32'h1);
      check("bp_valid_clr", 32'(rsp_valid), 32'h0);
      step();
      step();

      // Reset mid-operation
      set_req(2, OP_AND, 19'h55555, 19'h7FFFF);
      req_valid = 4'b0100;
      @(negedge clk);
      check("mid_grant", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'h1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
      check("mid_busy_clr", 32'(busy), 32'h0);
      step();
      set_req(0, OP_AND, 19'h7FFFF, 19'h00001);
      req_valid = 4'b1111;
      @(negedge clk);
      check("mid_regrant", 32'(req_ready), 32'h1);
      sb.push_back('{id: 2'd0, data: 19'h00001, err: 1'b0});
      step();
      req_valid = '0;
      step();
      step();

      // Illegal opcode
      set_req(1, 5'h1F, 19'h7FFFF, 19'h7FFFF);
      req_valid = 4'b0010;
      @(negedge clk);
      check("ill_grant", 32'(req_ready), 32'h2);
      sb.push_back('{id: 2'd1, data: 19'h00000, err: 1'b1});
      step();
      req_valid = '0;
      step();
      @(negedge clk);
      check("ill_data", 32'(rsp_data), 32'h0);
      step();
      step(); step(); step();

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one combinational logical unit among `NUM_REQ` requesters in the 19-bit CPU. Each requester presents an opcode and two operands over a valid/ready handshake. The block grants one requester at a time, registers its operands onto the shared unit's inputs, captures the unit's result, and returns it on a single response channel tagged with the requester index. It sits between the issue logic and the logical unit.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `WORD_SIZE`, 19, operand/result width
- `OPCODE_SIZE`, 5, opcode width; encodings come from the `opcodes` package (`AND`, `OR`, `XOR`, `NOT`)
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept, at most one bit set.
- `req_opcode` in `NUM_REQ*OPCODE_SIZE`: flattened opcodes; requester i occupies slice [i*OPCODE_SIZE +: OPCODE_SIZE].
- `req_operand_1`, `req_operand_2` in `NUM_REQ*WORD_SIZE` each: flattened operands.
- `lu_opcode` out `OPCODE_SIZE`: registered opcode to the shared unit.
- `lu_operand_1`, `lu_operand_2` out `WORD_SIZE` each: registered operands to the shared unit.
- `lu_out` in `WORD_SIZE`: the shared unit's combinational result.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `$clog2(NUM_REQ)`: index of the granted requester.
- `rsp_data` out `WORD_SIZE`: captured result.
- `busy` out 1: high when the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req_valid` is high, grant one requester g by round-robin, searching upward from `last_grant+1` modulo `NUM_REQ`.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - On the clock edge, load `lu_*` from requester g's slices, store g in `rsp_id` and `last_grant`, then go to ISSUE.
- **ISSUE**
  - `lu_*` are held stable.
  - On the clock edge, capture `lu_out` into `rsp_data`, set `rsp_valid`, then go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` until `rsp_ready` is high.
  - On that handshake:
    - If any `req_valid` is high, grant the next requester exactly as IDLE does (`req_ready` asserted in this cycle), clear `rsp_valid`, and go to ISSUE.
    - Otherwise, clear `rsp_valid` and go to IDLE.
- `req_ready` is all-zero in ISSUE, and in RESP whenever `rsp_ready` is low.
- Requesters hold `req_*` stable while `req_valid && !req_ready`. The block does not check this.
- Opcodes are passed through unmodified. A non-logical opcode yields whatever the unit returns for its default case (0).
- After an IDLE cycle with no request, `lu_*` keep their last values.

## Timing
- Reset values:
  - state IDLE, `last_grant = NUM_REQ-1`, so requester 0 wins first.
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_data = 0`, `busy = 0`.
  - `lu_opcode = 0`, `lu_operand_1 = 0`, `lu_operand_2 = 0`.
- Latency: a request accepted in cycle T has `lu_*` valid in T+1 and `rsp_valid` high in T+2.
- Throughput: one operation per 2 cycles when `rsp_ready` is held high and requests are pending. One per 3 cycles if the block passes through IDLE.
- Fairness: under continuous requests from all requesters, each is granted once every `NUM_REQ` grants.
- Backpressure: while `rsp_ready` is low in RESP, all `rsp_*` outputs are frozen and no grant occurs.
- Simultaneous events: a response handshake and a new grant in the same RESP cycle are legal and expected.
- Reset mid-operation: `rst` in any state discards the in-flight operation. All outputs take their reset values on the next edge, and no response is emitted for it.
- Wrap-around: a search starting from `last_grant = NUM_REQ-1` begins at index 0.

## Configuration
- Macro: `LU_ARB_ERR_EN`.
- **Defined**
  - Adds output `rsp_err` (1 bit, reset 0).
  - In ISSUE, `rsp_err` is set if `lu_opcode` is not `AND`/`OR`/`XOR`/`NOT`. It is held and cleared together with `rsp_valid`.
  - `rsp_data` still carries `lu_out`.
- **Undefined**
  - The `rsp_err` port is absent.
  - Illegal opcodes are silently returned as the unit's default result (0).

## Test plan
- **Reset:** reset for 2 cycles, then `req_valid=0` → all outputs 0, `busy=0`.
- **Single AND:** requester 2 issues `AND`, 0x7FFFF, 0x0F0F0; `rsp_ready=1` → `req_ready[2]` high in the accept cycle; two cycles later `rsp_valid=1`, `rsp_id=2`, `rsp_data=0x0F0F0`.
- **Round-robin:** all 4 requesters issue `XOR` with operand_1=i, operand_2=0x40000 and hold valid → grant order 0,1,2,3,0; `rsp_data=0x40000|i`; one response every 2 cycles.
- **Backpressure:** `NOT` 0x00000 with `rsp_ready=0` for 5 cycles → `rsp_valid`, `rsp_data=0x7FFFF` and `rsp_id` stable; `req_ready` all 0; on `rsp_ready=1` there is exactly one handshake.
- **Reset mid-operation:** assert `rst` in ISSUE → no response emitted; next grant goes to requester 0.
- **Illegal opcode:** opcode 5'h1F with `LU_ARB_ERR_EN` defined → `rsp_data=0` and `rsp_err=1`. Without the macro → `rsp_data=0`.
